csa_stream_accum: RTL and testbench
===================================

Name: csa_stream_accum

Overview:
- Parametrised multi-lane carry-save accumulator for the MMH-MH privacy-amplification datapath.
- Each accepted beat carries up to LANES W-bit operands. They are folded into a redundant partial-sum/shift-carry pair through a CSA tree, with no carry propagation in the accumulate loop.
- On the frame's last beat, a chunked carry-propagate stage resolves the pair over W/CPA_CHUNK cycles. It presents the result modulo 2^W on a valid/ready output.

Parameters:
- W, 192, operand and accumulator width in bits.
- LANES, 4, operands per input beat; legal range 1..8.
- CPA_CHUNK, 64, bits resolved per cycle in the carry-propagate stage; W must be a multiple of CPA_CHUNK.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  LANES*W  operands; lane k is bits [k*W +: W].
- in_lane_en  input  LANES  per-lane enable; a disabled lane contributes 0.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W  (sum of all enabled operands in the frame) mod 2^W.
- out_count  output  CNT_W  beats accepted in the frame, saturating at 2^CNT_W-1.
- busy  output  1  high when the state is not ACCUM, or when the accumulator is nonzero.

Behaviour:
- Reset (asynchronous, rst_n=0): state=ACCUM; ps, sc, out_sum, out_count, out_valid and the beat counter are all 0.
  - in_ready=1 and busy=0 from the first clock after release.
  - Reset during any state aborts the frame. No partial result is ever presented.
- Handshake: a beat is accepted on a rising edge with in_valid & in_ready. Result transfer occurs on an edge with out_valid & out_ready.
  - in_ready = (state==ACCUM), purely combinational from state.
  - out_valid = (state==DONE).
  - in_data is ignored when not accepted.
- States:
  - ACCUM: on each accepted beat, (ps,sc) <= CSA reduction of {ps, sc, masked lanes}.
    - Reduction uses cascaded 3:2 compressors. The carry vector of each compressor is majority<<1, with bit W-1's carry discarded (mod 2^W).
    - Counter increments, saturating.
    - If in_last is set on the beat, go to RESOLVE with chunk index i=0 and carry-in 0.
  - RESOLVE: each cycle, out_sum[i*CPA_CHUNK +: CPA_CHUNK] <= ps chunk + sc chunk + cin; cin <= carry-out of that chunk; i++.
    - After chunk NCH-1 (NCH=W/CPA_CHUNK), go to DONE.
    - The final carry-out is discarded.
  - DONE: out_sum and out_count are held stable while out_valid=1 and out_ready=0.
    - On transfer: ps, sc and the counter clear to 0 and the state returns to ACCUM.
    - in_ready rises the cycle after the transfer edge; there is no same-cycle bypass.
- Latency: if the last beat is accepted at edge E0, out_valid is 1 after edge E0+NCH. For the defaults, that is 3 cycles later.
  - Throughput: one beat per cycle during ACCUM.
  - A frame costs beats + NCH + 1 cycles minimum.
- Boundaries:
  - A single-beat frame (in_last on the first beat) is legal.
  - A last beat with in_lane_en=0 still ends the frame and is counted.
  - An all-zero frame gives out_sum=0.
  - out_count saturates and does not wrap.
  - out_sum and out_count retain the last result after transfer until the next DONE.
- Arithmetic invariant: in ACCUM, (ps+sc) mod 2^W equals the running sum mod 2^W after every accepted beat. The bench checks this through a debug compare.

Test Plan:
- Reset then idle -> out_valid=0, out_sum=0, out_count=0, busy=0, in_ready=1 on the first edge after rst_n=1.
- One beat, lanes=1,2,3,4, en=4'b1111, last=1 -> out_valid 3 edges later, out_sum=10, out_count=1; a transfer with out_ready=1 returns in_ready=1 on the next cycle.
- Two beats, all lanes=2^192-1, en=all, last on the second beat -> out_sum=2^192-8, out_count=2 (wrap mod 2^W).
- Mask: lanes=5,7,9,11, en=4'b0101 -> out_sum=14; a subsequent frame with lane0=2^64-1, lane1=1 -> out_sum=2^64 (carry crosses a chunk boundary).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_sum and out_count are stable, in_valid pulses are not accepted, in_ready=0; after release, the next frame is correct.
- Reset asserted during RESOLVE chunk 1 -> all outputs 0 immediately and no out_valid; the next frame of 3 beats (lane0=100 each) gives out_sum=300, out_count=3.

Source files
------------

// File: rtl/csa_stream_accum.sv
// ---------------------------------------------------------------------------
// csa_stream_accum
//
// Multi-lane carry-save accumulator for the MMH-MH privacy-amplification
// datapath. Each accepted beat folds up to LANES operands into a redundant
// (ps, sc) pair through a chain of 3:2 compressors. The accumulate loop
// never propagates a carry. On the last beat of a frame, a chunked
// carry-propagate stage resolves the pair, one CPA_CHUNK slice per cycle.
// The result (mod 2^W) is then presented on a valid/ready output.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (aborts any frame in flight)
//   in_valid    input beat valid
//   in_ready    block can accept a beat (high only while accumulating)
//   in_data     LANES operands, lane k at bits [k*W +: W]
//   in_lane_en  per-lane enable, a disabled lane contributes zero
//   in_last     final beat of the frame
//   out_valid   result valid (held until out_ready)
//   out_ready   downstream accepts the result
//   out_sum     sum of all enabled operands of the frame, mod 2^W
//   out_count   beats accepted in the frame, saturating
//   busy        high when not accumulating or when the accumulator is nonzero
// ---------------------------------------------------------------------------
module csa_stream_accum #(
    parameter int W         = 192,
    parameter int LANES     = 4,
    parameter int CPA_CHUNK = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    input  logic [LANES-1:0]     in_lane_en,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 busy
);

    localparam int NCH   = W / CPA_CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]           state;
    logic [W-1:0]         ps;
    logic [W-1:0]         sc;
    logic [CNT_W-1:0]     beat_cnt;
    logic [IDX_W-1:0]     idx;
    logic                 cin;

    logic [W-1:0]         csa_s;
    logic [W-1:0]         csa_c;
    logic [W-1:0]         lane_v;
    logic [W-1:0]         maj_v;

    logic [CPA_CHUNK-1:0] ps_chunk;
    logic [CPA_CHUNK-1:0] sc_chunk;
    logic [CPA_CHUNK:0]   chunk_full;
    logic [W-1:0]         sum_next;
    logic                 last_chunk;
    logic                 accept;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_ACCUM) | (|ps) | (|sc);
    assign accept    = in_valid & in_ready;

    // The CSA chain starts from the current (ps, sc) pair. Each lane then
    // goes through one 3:2 compressor. The carry vector is the majority
    // shifted left by one, and the carry out of bit W-1 falls off the top.
    // That gives the mod 2^W wrap without any extra logic.
    always_comb begin
        csa_s  = ps;
        csa_c  = sc;
        lane_v = '0;
        maj_v  = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_v = in_lane_en[k] ? in_data[k*W +: W] : '0;
            maj_v  = (csa_s & csa_c) | (csa_s & lane_v) | (csa_c & lane_v);
            csa_s  = csa_s ^ csa_c ^ lane_v;
            csa_c  = {maj_v[W-2:0], 1'b0};
        end
    end

    // Chunk selection for the carry-propagate stage uses a constant-slice
    // mux, so no variable part-select reaches synthesis. sum_next is
    // out_sum with only the chunk currently being resolved replaced.
    always_comb begin
        ps_chunk = '0;
        sc_chunk = '0;
        for (int j = 0; j < NCH; j++) begin
            if (idx == IDX_W'(j)) begin
                ps_chunk = ps[j*CPA_CHUNK +: CPA_CHUNK];
                sc_chunk = sc[j*CPA_CHUNK +: CPA_CHUNK];
            end
        end
        chunk_full = {1'b0, ps_chunk} + {1'b0, sc_chunk} + (CPA_CHUNK+1)'(cin);
        sum_next   = out_sum;
        for (int j = 0; j < NCH; j++) begin
            if (idx == IDX_W'(j)) begin
                sum_next[j*CPA_CHUNK +: CPA_CHUNK] = chunk_full[CPA_CHUNK-1:0];
            end
        end
        last_chunk = (idx == IDX_W'(NCH-1));
    end

    // Main control. ACCUM folds beats into the redundant pair. RESOLVE
    // ripples one chunk per cycle and drops the final carry. DONE holds
    // the result until the handshake, then clears the accumulator.
    // out_sum/out_count deliberately survive the transfer, so the last
    // result stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            ps        <= '0;
            sc        <= '0;
            beat_cnt  <= '0;
            idx       <= '0;
            cin       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        ps <= csa_s;
                        sc <= csa_c;
                        if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        if (in_last) begin
                            state <= ST_RESOLVE;
                            idx   <= '0;
                            cin   <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    out_sum <= sum_next;
                    cin     <= chunk_full[CPA_CHUNK];
                    if (last_chunk) begin
                        state     <= ST_DONE;
                        out_count <= beat_cnt;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        ps       <= '0;
                        sc       <= '0;
                        beat_cnt <= '0;
                        state    <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_stream_accum.sv
// ---------------------------------------------------------------------------
// tb_csa_stream_accum
//
// Scoreboard bench for csa_stream_accum. The expected frame result is
// pushed when the last beat is accepted. It is popped and compared when
// out_valid appears. A running reference sum is also compared against
// the DUT's internal (ps + sc) after every accepted beat.
// ---------------------------------------------------------------------------
module tb_csa_stream_accum;

    localparam int W         = 192;
    localparam int LANES     = 4;
    localparam int CPA_CHUNK = 64;
    localparam int CNT_W     = 16;
    localparam int NCH       = W / CPA_CHUNK;

    typedef struct {
        logic [W-1:0]     sum;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic [LANES-1:0]     in_lane_en;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_sum;
    logic [CNT_W-1:0]     out_count;
    logic                 busy;

    exp_t                 sb[$];
    logic [W-1:0]         run_sum;
    int                   run_beats;
    int                   compared   = 0;
    int                   mismatched = 0;

    csa_stream_accum #(
        .W(W), .LANES(LANES), .CPA_CHUNK(CPA_CHUNK), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_lane_en(in_lane_en),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_count(out_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Safety net so a stuck DUT can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drive one beat and wait (bounded) for acceptance. Then update the
    // reference model and check the carry-save invariant. On the last
    // beat, push the frame's expected result to the scoreboard.
    task automatic applyStimulus(input logic [LANES*W-1:0] data,
                                 input logic [LANES-1:0] en, input logic last);
        int           guard;
        logic [W-1:0] pair;
        guard      = 0;
        in_valid   = 1'b1;
        in_data    = data;
        in_lane_en = en;
        in_last    = last;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (en[k]) run_sum = run_sum + data[k*W +: W];
        end
        run_beats++;
        pair = dut.ps + dut.sc;
        checkOutput("csa_invariant", pair, run_sum);
        if (last) begin
            sb.push_back('{run_sum, (run_beats > 65535) ? CNT_W'(65535) : CNT_W'(run_beats)});
            run_sum   = '0;
            run_beats = 0;
        end
    endtask

    // Wait for out_valid and check latency against the scoreboard.
    // Optionally hold off out_ready while poking in_valid. Then complete
    // the transfer and check the post-transfer state.
    task automatic collectResult(input int hold);
        int               n;
        exp_t             e;
        logic             stable;
        logic [W-1:0]     pair0;
        logic [W-1:0]     pair;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 0, 1);
            return;
        end
        checkOutput("latency", n, NCH);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkOutput("out_sum", out_sum, e.sum);
        checkOutput("out_count", out_count, e.count);
        if (hold > 0) begin
            stable = 1'b1;
            pair0  = dut.ps + dut.sc;
            for (int h = 0; h < hold; h++) begin
                in_valid   = 1'b1;
                in_data    = pack4(randWord(), randWord(), randWord(), randWord());
                in_lane_en = '1;
                in_last    = h[0];
                tick();
                in_valid = 1'b0;
                in_last  = 1'b0;
                pair     = dut.ps + dut.sc;
                if (out_sum !== e.sum || out_count !== e.count || out_valid !== 1'b1 ||
                    in_ready !== 1'b0 || pair !== pair0) stable = 1'b0;
            end
            checkOutput("backpressure_hold", stable, 1);
        end
        checkOutput("in_ready_in_done", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("in_ready_after_xfer", in_ready, 1);
        checkOutput("out_valid_after_xfer", out_valid, 0);
        checkOutput("sum_retained", out_sum, e.sum);
        checkOutput("busy_after_xfer", busy, 0);
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] low64;
        logic         seen;
        ones       = '1;
        low64      = {{(W-64){1'b0}}, {64{1'b1}}};
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_lane_en = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        run_sum    = '0;
        run_beats  = 0;

        // Reset, then idle.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sum", out_sum, 0);
        checkOutput("rst_out_count", out_count, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        // Single beat 1+2+3+4 = 10.
        applyStimulus(pack4(1, 2, 3, 4), 4'b1111, 1'b1);
        collectResult(0);

        // Two all-ones beats wrap to 2^W - 8.
        applyStimulus(pack4(ones, ones, ones, ones), 4'b1111, 1'b0);
        checkOutput("busy_accumulating", busy, 1);
        applyStimulus(pack4(ones, ones, ones, ones), 4'b1111, 1'b1);
        collectResult(0);

        // Lane mask: 5 + 9 = 14.
        applyStimulus(pack4(5, 7, 9, 11), 4'b0101, 1'b1);
        collectResult(0);

        // The carry crosses the chunk-0/chunk-1 boundary, giving 2^64.
        applyStimulus(pack4(low64, 1, 0, 0), 4'b0011, 1'b1);
        collectResult(0);

        // Backpressure for 10 cycles, then a normal frame.
        applyStimulus(pack4(randWord(), randWord(), randWord(), randWord()), 4'b1011, 1'b0);
        applyStimulus(pack4(randWord(), randWord(), randWord(), randWord()), 4'b1111, 1'b1);
        collectResult(10);

        // Random frame whose last beat has every lane disabled.
        applyStimulus(pack4(randWord(), randWord(), randWord(), randWord()), 4'($urandom), 1'b0);
        applyStimulus(pack4(randWord(), randWord(), randWord(), randWord()), 4'($urandom), 1'b0);
        applyStimulus(pack4(randWord(), randWord(), randWord(), randWord()), 4'b0000, 1'b1);
        collectResult(0);

        // All-zero frame.
        applyStimulus(pack4(0, 0, 0, 0), 4'b1111, 1'b0);
        applyStimulus(pack4(0, 0, 0, 0), 4'b1111, 1'b1);
        collectResult(0);

        // Reset in RESOLVE chunk 1 aborts the frame.
        applyStimulus(pack4(12345, 0, 0, 0), 4'b0001, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_sum", out_sum, 0);
        checkOutput("abort_out_count", out_count, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checkOutput("no_partial_result", seen, 0);

        // Recovery frame: 3 x 100 = 300.
        applyStimulus(pack4(100, 0, 0, 0), 4'b0001, 1'b0);
        applyStimulus(pack4(100, 0, 0, 0), 4'b0001, 1'b0);
        applyStimulus(pack4(100, 0, 0, 0), 4'b0001, 1'b1);
        collectResult(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
